// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//
// Contents:
//   ctr_e        2-bit saturating direction counter encodings
//   CTR_RESET    counter value loaded by reset (weakly not-taken)
//   ctr_next()   saturating increment (taken) / decrement (not taken)
//   bp_entry_t   BTB entry layout for the default geometry
//                (BP_XLEN / BP_ENTRIES). bp_btb builds the same layout
//                locally from its own parameters, so non-default
//                geometries stay consistent with this one.
package bp_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 64;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX - 2;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic                is_jump;
  } bp_entry_t;

  // Saturating 2-bit counter step: the ends stick instead of wrapping.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e r;
    r = c;
    case (c)
      CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  r = taken ? CTR_ST  : CTR_WT;
      default: r = CTR_RESET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer (valid, tag, target, is_jump)
// with a combinational lookup port and one write port.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears all entries)
//   lk_pc           lookup PC
//   lk_hit          entry valid and tag matches lk_pc
//   lk_is_jump      stored is_jump bit (0 when !lk_hit)
//   lk_target       stored target (0 when !lk_hit)
//   wr_en           write the entry selected by wr_pc at this posedge
//   wr_pc           PC providing index and tag for the write
//   wr_target       target to store
//   wr_is_jump      is_jump bit to store
//
// A write always marks the entry valid and replaces whatever tag was there.
// Lookups see the pre-write contents in the write cycle (no bypass).
module bp_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_is_jump,
  output logic [XLEN-1:0] lk_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_is_jump
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
  } btb_entry_t;

  btb_entry_t entry_q [ENTRIES];

  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  btb_entry_t       lk_entry;
  btb_entry_t       wr_entry_d;

  // Instructions are word aligned; the two low PC bits carry no information.
  logic [3:0] unused_pc_lsbs;
  assign unused_pc_lsbs = {lk_pc[1:0], wr_pc[1:0]};

  assign lk_idx = lk_pc[IDX+1:2];
  assign lk_tag = lk_pc[XLEN-1:IDX+2];
  assign wr_idx = wr_pc[IDX+1:2];
  assign wr_tag = wr_pc[XLEN-1:IDX+2];

  always_comb begin
    lk_entry   = entry_q[lk_idx];
    lk_hit     = 1'b0;
    lk_is_jump = 1'b0;
    lk_target  = '0;
    if (lk_entry.valid && (lk_entry.tag == lk_tag)) begin
      lk_hit     = 1'b1;
      lk_is_jump = lk_entry.is_jump;
      lk_target  = lk_entry.target;
    end
  end

  always_comb begin
    wr_entry_d         = '0;
    wr_entry_d.valid   = 1'b1;
    wr_entry_d.tag     = wr_tag;
    wr_entry_d.target  = wr_target;
    wr_entry_d.is_jump = wr_is_jump;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_en) begin
      entry_q[wr_idx] <= wr_entry_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch predictor for the 5-stage RISC-V pipeline.
// IF looks up the fetch PC combinationally; ID reports resolved control-flow
// instructions and receives the mispredict flag and redirect PC.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   if_pc             fetch PC to predict
//   pred_hit          BTB tag match for if_pc
//   pred_taken        predicted taken (jumps always, branches by counter MSB)
//   pred_target       predicted target, 0 when !pred_hit
//   upd_valid         ID reports a resolved branch/JAL/JALR this cycle
//   upd_pc            PC of the resolved instruction
//   upd_is_jump       1 = JAL/JALR, 0 = conditional branch
//   upd_taken         actual direction (1 for jumps)
//   upd_target        actual target
//   upd_pred_taken    prediction that travelled with the instruction
//   upd_pred_target   predicted target that travelled with it
//   mispredict        flush IF/ID and redirect (combinational from upd_*)
//   redirect_pc       correct next PC, meaningful while mispredict = 1
//
// Optional feature: define BP_GSHARE_EN to index the counter array with
// pc index XOR a GHR_W-bit global history (GHR_W must not exceed
// log2(ENTRIES)). The history shifts in the outcome of every resolved
// conditional branch; jumps leave it alone and it is never repaired
// speculatively. BTB indexing is the same in both builds.
//
// Update protocol: upd_valid is a single-cycle strobe per resolved
// instruction; there is no ready/backpressure, the write lands at the
// posedge where upd_valid = 1 and lookups in that cycle see the old state.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int GHR_W   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX = $clog2(ENTRIES);

  // ------------------------------------------------------------------
  // BTB
  // ------------------------------------------------------------------
  logic            btb_hit;
  logic            btb_is_jump;
  logic [XLEN-1:0] btb_target;
  logic            btb_wr_en;

  // Jumps always (re)write, so a JALR's latest target replaces the old one.
  // Not-taken branches never allocate.
  assign btb_wr_en = upd_valid && (upd_is_jump || upd_taken);

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lk_pc      (if_pc),
    .lk_hit     (btb_hit),
    .lk_is_jump (btb_is_jump),
    .lk_target  (btb_target),
    .wr_en      (btb_wr_en),
    .wr_pc      (upd_pc),
    .wr_target  (upd_target),
    .wr_is_jump (upd_is_jump)
  );

  // ------------------------------------------------------------------
  // Counter indexing (optionally hashed with global history)
  // ------------------------------------------------------------------
  logic [IDX-1:0] lk_cidx;
  logic [IDX-1:0] up_cidx;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  logic [GHR_W:0]   ghr_shift;

  // Oldest outcome drops off the top; newest enters at bit 0.
  assign ghr_shift = {ghr_q, upd_taken};

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && !upd_is_jump) begin
      ghr_d = ghr_shift[GHR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Lookup and update both hash with the current (resolve-time) history.
  assign lk_cidx = if_pc[IDX+1:2]  ^ IDX'(ghr_q);
  assign up_cidx = upd_pc[IDX+1:2] ^ IDX'(ghr_q);
`else
  assign lk_cidx = if_pc[IDX+1:2];
  assign up_cidx = upd_pc[IDX+1:2];
`endif

  // ------------------------------------------------------------------
  // Direction counters
  // ------------------------------------------------------------------
  ctr_e       ctr_q [ENTRIES];
  ctr_e       ctr_d;
  ctr_e       lk_ctr;
  logic [1:0] lk_ctr_bits;

  always_comb begin
    ctr_d = ctr_q[up_cidx];
    if (upd_is_jump) begin
      ctr_d = CTR_ST;
    end else begin
      ctr_d = ctr_next(ctr_q[up_cidx], upd_taken);
    end
  end

  // Not-taken branches that miss the BTB still train the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (upd_valid) begin
      ctr_q[up_cidx] <= ctr_d;
    end
  end

  // ------------------------------------------------------------------
  // Prediction outputs
  // ------------------------------------------------------------------
  assign lk_ctr      = ctr_q[lk_cidx];
  assign lk_ctr_bits = lk_ctr;

  assign pred_hit    = btb_hit;
  assign pred_taken  = btb_hit && (btb_is_jump || lk_ctr_bits[1]);
  assign pred_target = btb_target;

  // ------------------------------------------------------------------
  // Resolution outputs
  // ------------------------------------------------------------------
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));

endmodule
